// File: rtl/err_eval_pkg.sv
// rtl/err_eval_pkg.sv - shared state enum, width helpers and run-length constant for madd_err_accum
package err_eval_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_N_OUT = 12;
   localparam int DEF_N_IN  = 18;

   // FLUSH cycles after the last sample, chosen so done lands 3 cycles after it
   localparam int FLUSH_CYCLES = 2;

   // error counter must hold 2^n_in itself
   function automatic int errcnt_w(input int n_in);
      return n_in + 1;
   endfunction

   // 2^n_in samples of at most 2^n_out-1 each
   function automatic int sumabs_w(input int n_in, input int n_out);
      return n_in + n_out;
   endfunction

   // 2^n_in samples of at most (2^n_out-1)^2 each
   function automatic int sumsq_w(input int n_in, input int n_out);
      return n_in + 2 * n_out;
   endfunction

   // number of valid samples that make up one run
   function automatic longint unsigned sample_count(input int n_in);
      return 64'd1 << n_in;
   endfunction

endpackage

// File: rtl/err_absdiff.sv
// rtl/err_absdiff.sv - stage 1: registered unsigned absolute difference and mismatch flag
module err_absdiff
   import err_eval_pkg::*;
#(
   parameter int N_OUT = DEF_N_OUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [N_OUT-1:0] i_a,
   input  logic [N_OUT-1:0] i_b,
   output logic             o_valid,
   output logic             o_mis,
   output logic [N_OUT-1:0] o_diff
);

   logic [N_OUT-1:0] w_diff;
   logic             r_valid;
   logic             r_mis;
   logic [N_OUT-1:0] r_diff;

   // subtract the smaller from the larger so the result never wraps
   always_comb begin
      w_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
   end

   // stage-1 register; valid is dropped on reset or when a new run begins
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_valid <= 1'b0;
         r_mis   <= 1'b0;
         r_diff  <= '0;
      end else begin
         r_valid <= i_valid;
         r_mis   <= (i_a != i_b);
         r_diff  <= w_diff;
      end
   end

   assign o_valid = r_valid;
   assign o_mis   = r_mis;
   assign o_diff  = r_diff;

endmodule

// File: rtl/madd_err_accum.sv
// rtl/madd_err_accum.sv - error-metric accumulator for approximate circuits; ERR_SQ_EN adds sum_sq
module madd_err_accum
   import err_eval_pkg::*;
#(
   parameter int N_OUT = DEF_N_OUT,
   parameter int N_IN  = DEF_N_IN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [N_OUT-1:0]        approx_res,
   input  logic [N_OUT-1:0]        exact_res,
   output logic                    busy,
   output logic                    done,
   output logic [N_IN:0]           err_cnt,
   output logic [N_IN+N_OUT-1:0]   sum_abs,
`ifdef ERR_SQ_EN
   output logic [N_IN+2*N_OUT-1:0] sum_sq,
`endif
   output logic [N_OUT-1:0]        max_abs
);

   localparam int W_EC = errcnt_w(N_IN);
   localparam int W_SA = sumabs_w(N_IN, N_OUT);
   localparam logic [N_IN:0] LAST_IDX = W_EC'(sample_count(N_IN) - 64'd1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_flush_cnt;
   logic [N_IN:0]     r_smp_cnt;
   logic              w_take;
   logic              w_clear;
   logic              w_last;

   logic              w_s1_valid;
   logic              w_s1_mis;
   logic [N_OUT-1:0]  w_s1_diff;

   logic [W_EC-1:0]   r_err_cnt;
   logic [W_SA-1:0]   r_sum_abs;
   logic [N_OUT-1:0]  r_max_abs;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic; start outside IDLE never reaches here as a transition
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_RUN;
         ST_RUN:   if (in_valid && w_last) w_state_nxt = ST_FLUSH;
         ST_FLUSH: if (r_flush_cnt == 2'(FLUSH_CYCLES)) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // output decode and per-cycle control strobes
   always_comb begin
      busy    = (r_state == ST_RUN) || (r_state == ST_FLUSH);
      done    = (r_state == ST_DONE);
      w_take  = (r_state == ST_RUN) && in_valid;
      w_clear = (r_state == ST_IDLE) && start;
      w_last  = (r_smp_cnt == LAST_IDX);
   end

   // cycles spent in FLUSH while the pipeline drains
   always_ff @(posedge clk) begin
      if (rst || (r_state != ST_FLUSH)) begin
         r_flush_cnt <= 2'd0;
      end else begin
         r_flush_cnt <= r_flush_cnt + 2'd1;
      end
   end

   // valid samples taken this run; gaps in in_valid do not advance it
   always_ff @(posedge clk) begin
      if (rst || (r_state == ST_IDLE)) begin
         r_smp_cnt <= '0;
      end else if (w_take) begin
         r_smp_cnt <= r_smp_cnt + 1'b1;
      end
   end

   err_absdiff #(
      .N_OUT (N_OUT)
   ) u_absdiff (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_clear),
      .i_valid (w_take),
      .i_a     (approx_res),
      .i_b     (exact_res),
      .o_valid (w_s1_valid),
      .o_mis   (w_s1_mis),
      .o_diff  (w_s1_diff)
   );

   // stage 2: accumulate; results hold whenever no stage-1 sample is valid
   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_err_cnt <= '0;
         r_sum_abs <= '0;
         r_max_abs <= '0;
      end else if (w_s1_valid) begin
         r_err_cnt <= r_err_cnt + W_EC'(w_s1_mis);
         r_sum_abs <= r_sum_abs + W_SA'(w_s1_diff);
         if (w_s1_diff > r_max_abs) begin
            r_max_abs <= w_s1_diff;
         end
      end
   end

   assign err_cnt = r_err_cnt;
   assign sum_abs = r_sum_abs;
   assign max_abs = r_max_abs;

`ifdef ERR_SQ_EN
   localparam int W_SQ = sumsq_w(N_IN, N_OUT);

   logic [2*N_OUT-1:0] w_sq;
   logic [W_SQ-1:0]    r_sum_sq;

   // square of the stage-1 difference
   always_comb begin
      w_sq = (2*N_OUT)'(w_s1_diff) * (2*N_OUT)'(w_s1_diff);
   end

   // squared-error accumulator, cleared and qualified like the others
   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_sum_sq <= '0;
      end else if (w_s1_valid) begin
         r_sum_sq <= r_sum_sq + W_SQ'(w_sq);
      end
   end

   assign sum_sq = r_sum_sq;
`endif

endmodule

// File: doc/madd_err_accum.md
MADD_ERR_ACCUM -- requirements
Module: madd_err_accum

Interface
- REQ-001 SHALL have parameter N_OUT, default 12, width of the approximate and exact result words.
- REQ-002 SHALL have parameter N_IN, default 18, input-vector width of the circuit under evaluation; the sample count per run is 2^N_IN.
- REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
- REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port start, input, 1, single-cycle pulse that clears the accumulators and begins a run.
- REQ-006 SHALL have port in_valid, input, 1, sample qualifier.
- REQ-007 SHALL have port approx_res, input, N_OUT, approximate circuit output.
- REQ-008 SHALL have port exact_res, input, N_OUT, golden output.
- REQ-009 SHALL have port busy, output, 1, high from the start acceptance until done.
- REQ-010 SHALL have port done, output, 1, high for exactly one cycle when the final sample has been accumulated.
- REQ-011 SHALL have port err_cnt, output, N_IN+1, count of samples with approx_res != exact_res.
- REQ-012 SHALL have port sum_abs, output, N_IN+N_OUT, sum of |approx-exact|.
- REQ-013 SHALL have port max_abs, output, N_OUT, maximum |approx-exact| seen.
- REQ-014 SHALL have port sum_sq, output, N_IN+2*N_OUT, sum of squared error (present only when ERR_SQ_EN is defined).

Function
- REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> FLUSH when the 2^N_IN-th valid sample is taken; FLUSH -> DONE after the pipeline drains; DONE -> IDLE after one cycle.
- REQ-016 SHALL ignore in_valid outside RUN.
- REQ-017 SHALL ignore start when not in IDLE.
- REQ-018 SHALL treat operands as unsigned and compute the absolute difference without wrap.
- REQ-019 SHALL use a 2-stage pipeline: stage 1 registers abs diff and mismatch flag; stage 2 updates the accumulators.
- REQ-020 SHALL assert done 3 cycles after the final valid sample is sampled.
- REQ-021 SHALL size the accumulators so they cannot overflow at 2^N_IN worst-case samples; no saturation logic is needed.
- REQ-022 SHALL count gaps in in_valid as no samples; the run length is counted in valid samples only.
- REQ-023 SHALL hold the results stable from done until the next accepted start.
- REQ-024 SHALL clear the results in the cycle after start is accepted.
- REQ-025 SHALL treat start and the final sample in the same cycle with the final sample taking precedence and start ignored.

Reset
- REQ-026 SHALL, on rst, set the state to IDLE and drive busy=0, done=0, err_cnt=0, sum_abs=0, max_abs=0 and sum_sq=0, and invalidate the pipeline stages.
- REQ-027 SHALL, on rst asserted mid-run, abort the run without asserting done.

Configuration
- REQ-028 SHALL, with ERR_SQ_EN defined, compile the squarer and the sum_sq port and accumulator.
- REQ-029 SHALL, without ERR_SQ_EN, omit the sum_sq port and all squaring logic, leaving the other outputs bit-identical.

Structure
- REQ-030 SHALL place the FSM state enum, accumulator-width localparams and the sample-count constant function in package err_eval_pkg.
- REQ-031 SHALL place the stage-1 abs-diff/mismatch logic in sub-module err_absdiff.

Verification (N_IN=4, N_OUT=12 unless noted)
- REQ-032 SHALL cover: 16 samples with approx=exact -> done, err_cnt=0, sum_abs=0, max_abs=0.
- REQ-033 SHALL cover: 16 samples with approx=0, exact=4095 -> err_cnt=16, sum_abs=65520, max_abs=4095, sum_sq=268304400 with ERR_SQ_EN.
- REQ-034 SHALL cover: alternating diffs +3/-5 with random in_valid gaps -> err_cnt=16, sum_abs=64, max_abs=5; done exactly 3 cycles after the 16th valid sample.
- REQ-035 SHALL cover: rst after 7 samples, then start -> no done pulse for the aborted run; the fresh run gives correct totals.
- REQ-036 SHALL cover: start pulsed during RUN and in the cycle of the final sample -> ignored; totals unchanged.
- REQ-037 SHALL cover: N_IN=18, all-zero error except 1 at sample 262143 -> err_cnt=1, sum_abs=1.
